reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Receiving end of the common data bus: holds issued ops until both operands are
//  valid, snooping CDB_OUT broadcasts for outstanding tags, then dispatches one ready
//  op per cycle to its functional unit (ALU or LOAD). Sits between issue/rename and an
//  FU whose result re-enters the completion queue tagged with this entry's dest tag.
// PARAMETERS
//  DEPTH  4  number of entries (power of 2, >=2)
//  OP_W   4  width of opcode/alu_fun field carried to FU
// PORTS
//  CLK          in   1       clock, all state on posedge
//  RST_N        in   1       synchronous active-low reset
//  ISSUE_VALID  in   1       issue request this cycle
//  ISSUE_OP     in   OP_W    operation for FU
//  ISSUE_TAG    in   RS_tag  dest tag the FU result will carry
//  ISSUE_QJ/QK  in   RS_tag  producer tag of src j/k; INVALID = value present
//  ISSUE_VJ/VK  in   32      src j/k value (meaningful when Q==INVALID)
//  FULL         out  1       no free entry; issue must not be asserted
//  CDB_IN       in   cdb_t   {tag,data}; tag==INVALID = no broadcast
//  FU_READY     in   1       FU accepts a dispatch at this edge
//  DISP_VALID   out  1       one-cycle pulse: dispatch outputs valid
//  DISP_OP      out  OP_W    dispatched op
//  DISP_A/B     out  32      operand j/k values
//  DISP_TAG     out  RS_tag  dest tag of dispatched op
// BEHAVIOUR
//  Reset (RST_N=0 at edge): all busy=0, Qj/Qk=INVALID, RR pointer=0, DISP_VALID=0,
//   DISP_* =0, FULL=0. Reset wins over any simultaneous issue/CDB/dispatch.
//  Entry: busy, op, tag, Vj, Qj, Vk, Qk. ready = busy & Qj==INVALID & Qk==INVALID.
//  FULL = &busy (from registered state only; a slot freed at edge N is usable at N+1).
//  Issue: ISSUE_VALID & !FULL -> write lowest-index free entry at edge. Issue while
//   FULL is ignored, no state change. Same-cycle bypass: if ISSUE_Qx==CDB_IN.tag and
//   tag!=INVALID, store Vx=CDB_IN.data, Qx=INVALID (no lost wakeup).
//  Snoop: every busy entry with Qx==CDB_IN.tag (!=INVALID) captures Vx=data, Qx=INVALID
//   at the edge. Both operands may match the same broadcast. Multiple entries may match.
//  Dispatch: at edge, if FU_READY and any entry is ready (registered), select by round-
//   robin starting at RR pointer, drive DISP_* from it, DISP_VALID=1, clear its busy,
//   RR pointer <= selected+1 (mod DEPTH). Otherwise DISP_VALID=0, DISP_* hold.
//  Latency: issue with both operands valid at edge N -> DISP_VALID at N+1 (if FU_READY).
//   CDB wakeup at edge N -> earliest DISP_VALID at N+1.
//  Entry woken and selected never in the same edge; freed entry never re-written same edge.
//  FU_READY low: ready entries wait; no drop, no reorder of operands.
//  Tags unique among in-flight ops; ISSUE_TAG never INVALID (checked by assertion).
// STRUCTURE
//  cpu_types package: RS_tag_type, INVALID, cdb_t (existing); add rs_entry_t
//   {busy, op, tag, vj, qj, vk, qk} and RS_DEPTH default.
//  Sub-module rr_arbiter #(N=DEPTH): req vector + pointer -> one-hot grant, any_grant.
//  Free-slot find is a priority encoder inline; snoop/bypass compare is per-entry comb.
// TESTING
//  1 Reset: RST_N=0 2 cycles -> FULL=0, DISP_VALID=0, DISP_*=0; issue during reset ignored.
//  2 Issue Vj=5,Vk=7,Q=INVALID,TAG=T1, FU_READY=1 -> next edge DISP_VALID=1,A=5,B=7,TAG=T1.
//  3 Issue Qj=T2,Qk=T3; CDB T2/0x10 then T3/0x20 -> dispatch A=0x10,B=0x20 one cycle
//    after T3 broadcast, not before.
//  4 Issue with Qj=T4 in same cycle CDB_IN={T4,0xAA} -> entry ready, dispatch A=0xAA next edge.
//  5 Fill all DEPTH entries (Q pending) -> FULL=1, extra issue ignored; one broadcast
//    waking all, FU_READY=1 -> dispatches in round-robin order, one per cycle, FULL drops
//    the edge after first dispatch.
//  6 FU_READY=0 with 2 ready entries for 3 cycles -> no DISP_VALID; raise -> both
//    dispatch on consecutive cycles; RST_N=0 mid-stream -> all entries dropped.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: tag encoding, CDB broadcast and
// per-entry operand state.
package reservation_station_pkg;

  localparam int TAG_W    = 4;
  localparam int RS_DEPTH = 4;
  localparam int RS_OP_W  = 4;

  typedef logic [TAG_W-1:0] rs_tag_t;

  // Tag 0 is reserved: "operand value present" / "no broadcast this cycle".
  localparam rs_tag_t INVALID = '0;

  typedef struct packed {
    rs_tag_t     tag;
    logic [31:0] data;
  } cdb_t;

  // The opcode lives beside the entry so that the OP_W parameter can vary per instance.
  typedef struct packed {
    logic        busy;
    rs_tag_t     tag;
    logic [31:0] vj;
    rs_tag_t     qj;
    logic [31:0] vk;
    rs_tag_t     qk;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_rr_arbiter.sv
// Round-robin arbiter: the first request at or after ptr (wrapping) gets a
// one-hot grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 any_grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + IW'(i);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds issued ops and snoops the CDB until both operands
// are present. It dispatches one ready op per cycle in round-robin order.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int OP_W  = RS_OP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [OP_W-1:0] issue_op,
  input  rs_tag_t         issue_tag,
  input  rs_tag_t         issue_qj,
  input  rs_tag_t         issue_qk,
  input  logic [31:0]     issue_vj,
  input  logic [31:0]     issue_vk,
  output logic            full,
  input  cdb_t            cdb_in,
  input  logic            fu_ready,
  output logic            disp_valid,
  output logic [OP_W-1:0] disp_op,
  output logic [31:0]     disp_a,
  output logic [31:0]     disp_b,
  output rs_tag_t         disp_tag
);

  localparam int IW = $clog2(DEPTH);

  rs_entry_t       ent  [DEPTH];
  logic [OP_W-1:0] op_q [DEPTH];

  logic [DEPTH-1:0] busy_vec, ready_vec, grant;
  logic             any_grant, do_issue, do_disp, cdb_live;
  logic [IW-1:0]    rr_ptr, sel_idx, free_idx;
  rs_entry_t        new_ent;

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy && ent[i].qj == INVALID && ent[i].qk == INVALID;
    end
  end

  // Full comes from registered state only, so a slot freed at an edge can be reused at the next edge.
  assign full     = &busy_vec;
  assign do_issue = issue_valid && !full;
  assign do_disp  = fu_ready && any_grant;
  assign cdb_live = cdb_in.tag != INVALID;

  // Lowest-index free slot: scan downward so the last hit is the smallest index.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy_vec[i]) free_idx = IW'(i);
  end

  rr_arbiter #(.N(DEPTH)) u_arb (
    .req       (ready_vec),
    .ptr       (rr_ptr),
    .grant     (grant),
    .any_grant (any_grant)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) sel_idx = IW'(i);
  end

  // Same-cycle bypass: an operand broadcast in the issue cycle is captured now, so no wakeup is lost.
  always_comb begin
    new_ent.busy = 1'b1;
    new_ent.tag  = issue_tag;
    new_ent.vj   = issue_vj;
    new_ent.qj   = issue_qj;
    new_ent.vk   = issue_vk;
    new_ent.qk   = issue_qk;
    if (cdb_live && issue_qj == cdb_in.tag) begin
      new_ent.vj = cdb_in.data;
      new_ent.qj = INVALID;
    end
    if (cdb_live && issue_qk == cdb_in.tag) begin
      new_ent.vk = cdb_in.data;
      new_ent.qk = INVALID;
    end
  end

  // NOTE: entry state is reset because busy/Q decide behaviour; op_q is payload gated by busy and stays unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i]    <= '0;
        ent[i].qj <= INVALID;
        ent[i].qk <= INVALID;
      end
      rr_ptr     <= '0;
      disp_valid <= 1'b0;
      disp_op    <= '0;
      disp_a     <= '0;
      disp_b     <= '0;
      disp_tag   <= INVALID;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].busy && cdb_live && ent[i].qj == cdb_in.tag) begin
          ent[i].vj <= cdb_in.data;
          ent[i].qj <= INVALID;
        end
        if (ent[i].busy && cdb_live && ent[i].qk == cdb_in.tag) begin
          ent[i].vk <= cdb_in.data;
          ent[i].qk <= INVALID;
        end
      end

      disp_valid <= do_disp;
      if (do_disp) begin
        ent[sel_idx].busy <= 1'b0;
        disp_op           <= op_q[sel_idx];
        disp_a            <= ent[sel_idx].vj;
        disp_b            <= ent[sel_idx].vk;
        disp_tag          <= ent[sel_idx].tag;
        rr_ptr            <= sel_idx + IW'(1);
      end

      // The free slot is not busy in registered state, so it never collides with the snoop or dispatch writes above.
      if (do_issue) begin
        ent[free_idx]  <= new_ent;
        op_q[free_idx] <= issue_op;
      end
    end
  end

  a_issue_tag_valid : assert property (@(posedge clk) disable iff (!rst_n)
    issue_valid |-> issue_tag != INVALID);

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station covering reset, direct dispatch, CDB
// wakeup, bypass, full handling, FU backpressure and mid-stream reset.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [3:0]  issue_op;
  rs_tag_t     issue_tag, issue_qj, issue_qk;
  logic [31:0] issue_vj, issue_vk;
  logic        full;
  cdb_t        cdb_in;
  logic        fu_ready;
  logic        disp_valid;
  logic [3:0]  disp_op;
  logic [31:0] disp_a, disp_b;
  rs_tag_t     disp_tag;

  int n_tests = 0;
  int n_fail  = 0;

  reservation_station #(.DEPTH(4), .OP_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_tag   (issue_tag),
    .issue_qj    (issue_qj),
    .issue_qk    (issue_qk),
    .issue_vj    (issue_vj),
    .issue_vk    (issue_vk),
    .full        (full),
    .cdb_in      (cdb_in),
    .fu_ready    (fu_ready),
    .disp_valid  (disp_valid),
    .disp_op     (disp_op),
    .disp_a      (disp_a),
    .disp_b      (disp_b),
    .disp_tag    (disp_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input rs_tag_t tag, input rs_tag_t qj,
                       input logic [31:0] vj, input rs_tag_t qk, input logic [31:0] vk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_tag   = tag;
    issue_qj    = qj;
    issue_vj    = vj;
    issue_qk    = qk;
    issue_vk    = vk;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_op    = '0;
    issue_tag   = 4'd15;
    issue_qj    = INVALID;
    issue_qk    = INVALID;
    issue_vj    = '0;
    issue_vk    = '0;
  endtask

  task automatic bcast(input rs_tag_t tag, input logic [31:0] data);
    cdb_in.tag  = tag;
    cdb_in.data = data;
  endtask

  task automatic check_disp(input string name, input rs_tag_t tag,
                            input logic [31:0] a, input logic [31:0] b);
    check({name, "_valid"}, 32'(disp_valid), 32'd1);
    check({name, "_tag"},   32'(disp_tag),   32'(tag));
    check({name, "_a"},     disp_a,          a);
    check({name, "_b"},     disp_b,          b);
  endtask

  initial begin
    idle();
    bcast(INVALID, '0);
    fu_ready = 1'b1;

    // 1: reset for two cycles while an issue is presented; it must be ignored.
    rst_n = 1'b0;
    issue(4'd9, 4'd1, INVALID, 32'hDEAD, INVALID, 32'hBEEF);
    tick();
    tick();
    check("rst_full", 32'(full), 32'd0);
    check("rst_dv",   32'(disp_valid), 32'd0);
    check("rst_a",    disp_a, 32'd0);
    check("rst_b",    disp_b, 32'd0);
    check("rst_tag",  32'(disp_tag), 32'd0);
    check("rst_op",   32'(disp_op), 32'd0);
    rst_n = 1'b1;
    idle();
    tick();
    check("rst_no_entry0", 32'(disp_valid), 32'd0);
    tick();
    check("rst_no_entry1", 32'(disp_valid), 32'd0);

    // 2: both operands present: dispatched one edge after issue.
    issue(4'd3, 4'd1, INVALID, 32'd5, INVALID, 32'd7);
    tick();
    check("t2_not_yet", 32'(disp_valid), 32'd0);
    idle();
    tick();
    check_disp("t2", 4'd1, 32'd5, 32'd7);
    check("t2_op", 32'(disp_op), 32'd3);
    tick();
    check("t2_pulse", 32'(disp_valid), 32'd0);
    check("t2_hold_a", disp_a, 32'd5);

    // 3: two pending operands woken by separate broadcasts.
    issue(4'd5, 4'd4, 4'd2, 32'd0, 4'd3, 32'd0);
    tick();
    idle();
    bcast(4'd2, 32'h10);
    tick();
    check("t3_after_t2", 32'(disp_valid), 32'd0);
    bcast(4'd3, 32'h20);
    tick();
    check("t3_wake_edge", 32'(disp_valid), 32'd0);
    bcast(INVALID, '0);
    tick();
    check_disp("t3", 4'd4, 32'h10, 32'h20);
    tick();

    // 4: same-cycle bypass of the j operand.
    issue(4'd6, 4'd7, 4'd6, 32'd0, INVALID, 32'h55);
    bcast(4'd6, 32'hAA);
    tick();
    check("t4_not_yet", 32'(disp_valid), 32'd0);
    idle();
    bcast(INVALID, '0);
    tick();
    check_disp("t4", 4'd7, 32'hAA, 32'h55);
    tick();

    // 5: fill all entries (rr_ptr is 1 here), then issue while full and wake all at once.
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), rs_tag_t'(8 + i), 4'd12, 32'd0, INVALID, 32'(i + 1));
      tick();
    end
    check("t5_full", 32'(full), 32'd1);
    issue(4'd15, 4'd13, INVALID, 32'h77, INVALID, 32'h88);
    tick();
    check("t5_full_hold", 32'(full), 32'd1);
    check("t5_no_disp", 32'(disp_valid), 32'd0);
    idle();
    bcast(4'd12, 32'h100);
    tick();
    check("t5_wake_edge", 32'(disp_valid), 32'd0);
    bcast(INVALID, '0);
    tick();
    check_disp("t5_d0", 4'd9, 32'h100, 32'd2);
    check("t5_full_drop", 32'(full), 32'd0);
    tick();
    check_disp("t5_d1", 4'd10, 32'h100, 32'd3);
    tick();
    check_disp("t5_d2", 4'd11, 32'h100, 32'd4);
    tick();
    check_disp("t5_d3", 4'd8, 32'h100, 32'd1);
    tick();
    check("t5_drained", 32'(disp_valid), 32'd0);

    // 6: backpressure with two ready entries (rr_ptr is 1, so entry 1 goes first).
    fu_ready = 1'b0;
    issue(4'd1, 4'd1, INVALID, 32'h31, INVALID, 32'h32);
    tick();
    issue(4'd2, 4'd2, INVALID, 32'h41, INVALID, 32'h42);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_stall", 32'(disp_valid), 32'd0);
    end
    fu_ready = 1'b1;
    tick();
    check_disp("t6_d0", 4'd2, 32'h41, 32'h42);
    tick();
    check_disp("t6_d1", 4'd1, 32'h31, 32'h32);
    tick();
    check("t6_drained", 32'(disp_valid), 32'd0);

    // 6b: reset drops entries that are already waiting.
    fu_ready = 1'b0;
    issue(4'd3, 4'd5, INVALID, 32'h51, INVALID, 32'h52);
    tick();
    issue(4'd4, 4'd6, INVALID, 32'h61, INVALID, 32'h62);
    tick();
    idle();
    rst_n = 1'b0;
    fu_ready = 1'b1;
    tick();
    check("t6r_dv", 32'(disp_valid), 32'd0);
    check("t6r_a", disp_a, 32'd0);
    check("t6r_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6r_dropped", 32'(disp_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
